// File: rtl/dac_frame_rx.sv
// rtl/dac_frame_rx.sv - dual-lane serial DAC frame receiver (oversampled, clk domain)
//
// Listens to a two-lane DAC link (SCLK, NSYNC, SDATA1, SDATA2). The link is
// oversampled in the clk domain, each 16-bit DAC121S101-style frame is
// shifted in MSB first, and the 12-bit codes and power-down bits are
// presented as parallel words.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   SCLK         link serial clock (async to clk)
//   NSYNC        frame sync, active-low (async)
//   SDATA1/2     lane serial data, MSB first (async)
//   ch1/2_data   last complete lane data field
//   ch1/2_pd     last complete lane power-down bits (frame bits 13:12)
//   data_valid   one-cycle pulse when new words are loaded
//   frame_err    one-cycle pulse when a frame ended before FRAME_BITS clocks
//   frame_count  count of good frames, wraps
//   busy         high while a frame is in progress
module dac_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int DATA_W      = 12,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              NSYNC,
  input  logic              SDATA1,
  input  logic              SDATA2,
  output logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] ch2_data,
  output logic [1:0]        ch1_pd,
  output logic [1:0]        ch2_pd,
  output logic              data_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_count,
  output logic              busy
);

  localparam int BCW  = $clog2(FRAME_BITS + 1);
  // Only data + power-down bits are kept; the two leading frame bits fall
  // off the top of the shift register on their own.
  localparam int SR_W = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_WAIT_HI
  } state_t;

  // Synchronisers, reset to idle-line levels so reset release makes no edges.
  logic [SYNC_STAGES-1:0] sclk_sync_q, nsync_sync_q, sd1_sync_q, sd2_sync_q;
  logic                   sclk_prev_q, nsync_prev_q;

  logic sclk_s, nsync_s, sd1_s, sd2_s;
  logic sclk_fall, nsync_fall, nsync_rise;

  state_t            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]   sr1_q, sr1_d, sr2_q, sr2_d;
  logic              load, err_d;

  logic [DATA_W-1:0] ch1_data_q, ch2_data_q;
  logic [1:0]        ch1_pd_q, ch2_pd_q;
  logic              data_valid_q, frame_err_q;
  logic [CNT_W-1:0]  frame_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q  <= '1;
      nsync_sync_q <= '1;
      sd1_sync_q   <= '0;
      sd2_sync_q   <= '0;
      sclk_prev_q  <= 1'b1;
      nsync_prev_q <= 1'b1;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      nsync_sync_q <= {nsync_sync_q[SYNC_STAGES-2:0], NSYNC};
      sd1_sync_q   <= {sd1_sync_q[SYNC_STAGES-2:0], SDATA1};
      sd2_sync_q   <= {sd2_sync_q[SYNC_STAGES-2:0], SDATA2};
      sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
      nsync_prev_q <= nsync_sync_q[SYNC_STAGES-1];
    end
  end

  // Data is taken from the same stage as SCLK so lane data and clock stay aligned.
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign nsync_s    = nsync_sync_q[SYNC_STAGES-1];
  assign sd1_s      = sd1_sync_q[SYNC_STAGES-1];
  assign sd2_s      = sd2_sync_q[SYNC_STAGES-1];
  assign sclk_fall  = sclk_prev_q & ~sclk_s;
  assign nsync_fall = nsync_prev_q & ~nsync_s;
  assign nsync_rise = ~nsync_prev_q & nsync_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    load      = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nsync_fall) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          sr1_d     = '0;
          sr2_d     = '0;
        end
      end
      S_SHIFT: begin
        // A clock edge in the same cycle as NSYNC rising is counted first,
        // so a frame whose last edge coincides with the rise is still good.
        if (sclk_fall) begin
          sr1_d     = {sr1_q[SR_W-2:0], sd1_s};
          sr2_d     = {sr2_q[SR_W-2:0], sd2_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(FRAME_BITS - 1)) begin
            state_d = S_DONE;
          end else if (nsync_rise) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (nsync_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        load = 1'b1;
        // NSYNC may already have risen while the last bit was taken; check
        // the level so that rise is not waited for a second time.
        state_d = nsync_s ? S_IDLE : S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (nsync_rise) begin
          state_d = S_IDLE;
        end else if (nsync_fall) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          sr1_d     = '0;
          sr2_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      sr1_q         <= '0;
      sr2_q         <= '0;
      ch1_data_q    <= '0;
      ch2_data_q    <= '0;
      ch1_pd_q      <= '0;
      ch2_pd_q      <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr1_q        <= sr1_d;
      sr2_q        <= sr2_d;
      data_valid_q <= load;
      frame_err_q  <= err_d;
      if (load) begin
        ch1_data_q    <= sr1_q[DATA_W-1:0];
        ch2_data_q    <= sr2_q[DATA_W-1:0];
        ch1_pd_q      <= sr1_q[DATA_W+1:DATA_W];
        ch2_pd_q      <= sr2_q[DATA_W+1:DATA_W];
        frame_count_q <= frame_count_q + 1'b1;
      end
    end
  end

  assign ch1_data    = ch1_data_q;
  assign ch2_data    = ch2_data_q;
  assign ch1_pd      = ch1_pd_q;
  assign ch2_pd      = ch2_pd_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dac_frame_rx.sv
// tb/tb_dac_frame_rx.sv - self-checking bench for dac_frame_rx
module tb_dac_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        SCLK, NSYNC, SDATA1, SDATA2;
  logic [11:0] ch1_data, ch2_data;
  logic [1:0]  ch1_pd, ch2_pd;
  logic        data_valid, frame_err, busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  dac_frame_rx dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .NSYNC(NSYNC), .SDATA1(SDATA1), .SDATA2(SDATA2),
    .ch1_data(ch1_data), .ch2_data(ch2_data), .ch1_pd(ch1_pd), .ch2_pd(ch2_pd),
    .data_valid(data_valid), .frame_err(frame_err), .frame_count(frame_count), .busy(busy)
  );

  typedef struct {
    logic        good;
    logic [11:0] c1;
    logic [1:0]  p1;
    logic [11:0] c2;
    logic [1:0]  p2;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] l1;
    logic [15:0] l2;
    int          nbits;
    bit          sim;
    logic        good;
    logic [11:0] c1;
    logic [1:0]  p1;
    logic [11:0] c2;
    logic [1:0]  p2;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] m_cnt = 16'h0;

  localparam int NB = 300;

  // Scoreboard consumer: every data_valid / frame_err pulse must match the
  // oldest pending expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (data_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (data_valid || frame_err) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse valid=%0b err=%0b", data_valid, frame_err);
        end else begin
          mon_e = sb.pop_front();
          if (data_valid !== mon_e.good || frame_err !== !mon_e.good ||
              ch1_data !== mon_e.c1 || ch1_pd !== mon_e.p1 ||
              ch2_data !== mon_e.c2 || ch2_pd !== mon_e.p2 || frame_count !== mon_e.cnt) begin
            failures++;
            $display("FAIL frame_result actual v=%0b e=%0b c1=%h p1=%0d c2=%h p2=%0d cnt=%h expected v=%0b e=%0b c1=%h p1=%0d c2=%h p2=%0d cnt=%h",
                     data_valid, frame_err, ch1_data, ch1_pd, ch2_data, ch2_pd, frame_count,
                     mon_e.good, !mon_e.good, mon_e.c1, mon_e.p1, mon_e.c2, mon_e.p2, mon_e.cnt);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {17'h0, ch1_data, ch2_data, ch1_pd, ch2_pd, data_valid, frame_err, frame_count, busy};
  endfunction

  task automatic push_exp(input logic good, input logic [11:0] c1, input logic [1:0] p1,
                          input logic [11:0] c2, input logic [1:0] p2);
    exp_t e;
    if (good) m_cnt = m_cnt + 16'h1;
    e.good = good; e.c1 = c1; e.p1 = p1; e.c2 = c2; e.p2 = p2; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  // Transmitter model: data changes with SCLK rising, receiver samples on falling.
  task automatic send_frame(input logic [15:0] l1, input logic [15:0] l2, input int nbits,
                            input int hp, input bit sim, input bit no_end);
    NSYNC = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SDATA1 = (i < 16) ? l1[15-i] : 1'b0;
      SDATA2 = (i < 16) ? l2[15-i] : 1'b0;
      repeat (hp) @(negedge clk);
      SCLK = 1'b0;
      if (sim && i == nbits - 1) NSYNC = 1'b1;
      repeat (hp) @(negedge clk);
      SCLK = 1'b1;
    end
    if (!no_end) begin
      repeat (hp) @(negedge clk);
      NSYNC = 1'b1;
      repeat (hp) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
      sb.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    SCLK = 1'b1; NSYNC = 1'b1; SDATA1 = 1'b0; SDATA2 = 1'b0;
    m_cnt = 16'h0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  vec_t vt[6];
  int   vc0, ec0;
  logic [15:0] w1, w2;

  initial begin
    vt[0] = '{16'h0032, 16'h1FFF, 16, 1'b0, 1'b1, 12'h032, 2'd0, 12'hFFF, 2'd1};
    vt[1] = '{16'hAAAA, 16'h5555,  9, 1'b0, 1'b0, 12'h032, 2'd0, 12'hFFF, 2'd1};
    vt[2] = '{16'h2ABC, 16'hC123, 16, 1'b0, 1'b1, 12'hABC, 2'd2, 12'h123, 2'd0};
    vt[3] = '{16'h1234, 16'hF00F, 20, 1'b0, 1'b1, 12'h234, 2'd1, 12'h00F, 2'd3};
    vt[4] = '{16'h3FFF, 16'h0000, 16, 1'b1, 1'b1, 12'hFFF, 2'd3, 12'h000, 2'd0};
    vt[5] = '{16'hFFFF, 16'hFFFF,  1, 1'b0, 1'b0, 12'hFFF, 2'd3, 12'h000, 2'd0};

    // Reset held while the line toggles.
    rst = 1'b0;
    SCLK = 1'b1; NSYNC = 1'b1; SDATA1 = 1'b0; SDATA2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      SCLK = 1'($urandom_range(0, 1));
      NSYNC = 1'($urandom_range(0, 1));
      SDATA1 = 1'($urandom_range(0, 1));
      SDATA2 = 1'($urandom_range(0, 1));
      #1;
      if (i % 8 == 7) chk("reset_hold_outputs", all_outs(), 64'h0);
    end
    SCLK = 1'b1; NSYNC = 1'b1; SDATA1 = 1'b0; SDATA2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_reset_outputs", all_outs(), 64'h0);

    // Table-driven frames: good, short, long, simultaneous rise.
    for (int k = 0; k < 6; k++) begin
      push_exp(vt[k].good, vt[k].c1, vt[k].p1, vt[k].c2, vt[k].p2);
      send_frame(vt[k].l1, vt[k].l2, vt[k].nbits, 8, vt[k].sim, 1'b0);
      wait_drain($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_busy_idle", k), 64'(busy), 64'h0);
      chk($sformatf("vec%0d_frame_count", k), 64'(frame_count), 64'(m_cnt));
    end

    // Back-to-back frames at the fastest allowed SCLK.
    do_reset();
    vc0 = valid_cnt;
    ec0 = err_cnt;
    for (int n = 0; n < NB; n++) begin
      w1 = 16'(n);
      w2 = 16'(4095 - n);
      push_exp(1'b1, w1[11:0], 2'd0, w2[11:0], 2'd0);
      send_frame(w1, w2, 16, 4, 1'b0, 1'b0);
    end
    wait_drain("b2b");
    chk("b2b_valid_pulses", 64'(valid_cnt - vc0), 64'(NB));
    chk("b2b_err_pulses", 64'(err_cnt - ec0), 64'h0);
    chk("b2b_frame_count", 64'(frame_count), 64'(NB));

    // Reset in the middle of a frame, then a clean frame.
    send_frame(16'h0123, 16'h0456, 7, 8, 1'b0, 1'b1);
    chk("midframe_busy", 64'(busy), 64'h1);
    rst = 1'b0;
    SCLK = 1'b1; NSYNC = 1'b1; SDATA1 = 1'b0; SDATA2 = 1'b0;
    m_cnt = 16'h0;
    #1;
    chk("midframe_reset_outputs", all_outs(), 64'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_no_valid", 64'(valid_cnt - vc0), 64'(NB));
    push_exp(1'b1, 12'hABC, 2'd0, 12'h000, 2'd0);
    send_frame(16'h0ABC, 16'h0000, 16, 8, 1'b0, 1'b0);
    wait_drain("after_midreset");
    chk("after_midreset_count", 64'(frame_count), 64'h1);

    // frame_count wrap.
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    m_cnt = 16'hFFFF;
    push_exp(1'b1, 12'h555, 2'd0, 12'hAAA, 2'd2);
    send_frame(16'h0555, 16'h2AAA, 16, 8, 1'b0, 1'b0);
    wait_drain("wrap");
    chk("wrap_count", 64'(frame_count), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
